unsigned_divider: RTL and testbench
===================================

Name: unsigned_divider

Overview:
- Sequential N-bit unsigned restoring divider; the inverse-operation companion to the team's shift-add unsigned_multiplier.
- Uses the same load / done / recieved / init handshake, so the same controller or bench can drive either block.
- Produces quotient and remainder at one bit per clock, plus a divide-by-zero flag.
- Sits in the arithmetic datapath beside the multiplier.

Parameters:
- N, 32, operand width in bits; dividend, divisor, quotient and remainder are all N bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- load  input  1  start request; sampled only in IDLE.
- recieved  input  1  consumer acknowledge of the result; sampled only in DONE.
- A  input  N  dividend; captured on the accepted load edge.
- B  input  N  divisor; captured on the accepted load edge.
- done  output  1  result valid; high throughout DONE.
- init  output  1  ready; high throughout IDLE.
- Q  output  N  quotient, registered.
- R  output  N  remainder, registered.
- div_by_zero  output  1  high with done when the captured B was 0.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, Q=0, R=0, done=0, div_by_zero=0, counter=0, internal registers=0.
  - init=1 from the first post-reset cycle.
  - Reset applied mid-CALC or in DONE aborts the operation; no partial result is kept.
- States:
  - IDLE: init=1. load=1 at a posedge → capture A and B, go to CALC. If B==0, go to DONE instead.
  - CALC: init=0, done=0. One restoring step per clock. After N steps, go to DONE.
  - DONE: done=1. Stay until recieved=1 at a posedge, then go to IDLE.
- Datapath:
  - Remainder register REM is N+1 bits so the trial subtract cannot overflow when B ≥ 2^(N-1).
  - Quotient shift register QS is N bits; divisor register D is N bits.
  - On load: REM=0, QS=A, D=B, counter=0.
- Each CALC step:
  - Shift {REM,QS} left by 1.
  - Compute trial = REM − {1'b0,D}.
  - If trial ≥ 0: REM=trial, QS[0]=1. Otherwise REM is unchanged and QS[0]=0.
  - counter increments.
  - The step with counter==N−1 is the last; at that edge Q←QS_final, R←REM_final[N−1:0], div_by_zero←0, state←DONE.
- Latency:
  - Load accepted at edge k → done=1 from edge k+N (N CALC edges: k+1 … k+N).
  - Equivalently, done is first seen high N+1 clocks after load is driven high at an IDLE edge.
  - recieved accepted at edge m → done=0 and init=1 from edge m.
- Divide by zero (B==0 at load):
  - CALC is skipped; done=1 from edge k+1.
  - Q=all ones, R=A, div_by_zero=1.
- Output hold and event rules:
  - Q, R and div_by_zero hold their values after leaving DONE, until the next completed operation.
  - They are never updated mid-CALC.
  - load outside IDLE is ignored; A/B changes after capture have no effect.
  - recieved outside DONE is ignored.
  - load and recieved both high in DONE: recieved is honoured and the block returns to IDLE. That load is not accepted; it must be re-presented in IDLE.
  - Continuous load=1 in IDLE starts a new operation on the first IDLE edge after return.
- Arithmetic properties: for all B≠0, Q = floor(A/B), R = A mod B, and A = Q·B + R with R < B.

Test Plan:
- A=100, B=7, pulse load → done after exactly 33 clocks (N=32), Q=14, R=2, div_by_zero=0. Assert recieved → init=1 the next cycle.
- A=0xFFFFFFFF, B=0x80000001 → Q=1, R=0x7FFFFFFE. Also A=0xFFFFFFFF, B=1 → Q=0xFFFFFFFF, R=0. These check the N+1-bit remainder path.
- A=3, B=10 → Q=0, R=3. Also A=0, B=5 → Q=0, R=0.
- A=5, B=0 → done 2 clocks after load is driven, Q=0xFFFFFFFF, R=5, div_by_zero=1. A following A=9, B=3 operation → div_by_zero=0, Q=3, R=0.
- Start A=1000, B=3. Pulse load and change A/B again at CALC cycle 5 → ignored, Q=333, R=1. Repeat, then assert rst_n=0 at CALC cycle 10 → next cycle state=IDLE, done=0, Q=0, R=0, init=1.
- Back-to-back pairs 10/3, 20/5, 12345678/1234 with recieved and load both held high in DONE → each result correct, and no operation starts while in DONE. A random sweep of 1000 operand pairs checks A == Q·B+R and R<B.

Source files
------------

// File: rtl/unsigned_divider_if.sv
// Handshake and operand/result bundle shared by the unsigned divider and its driver.
// The master drives the request side; the slave (the divider) returns the result.
interface unsigned_divider_if #(
  parameter int N = 32
);
  logic         load;
  logic         recieved;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         done;
  logic         init;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  modport master (
    output load, recieved, A, B,
    input  done, init, Q, R, div_by_zero
  );

  modport slave (
    input  load, recieved, A, B,
    output done, init, Q, R, div_by_zero
  );
endinterface

// File: rtl/unsigned_divider.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock,
// with the load/done/recieved/init handshake of the shift-add multiplier.
module unsigned_divider #(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst_n,
  unsigned_divider_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [N:0]    rem_r;
  logic [N-1:0]  qs_r;
  logic [N-1:0]  d_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic          dbz_r;
  logic          done_r;
  logic          init_r;

  logic [N+1:0]  trial_s;
  logic [N:0]    rem_step_s;
  logic          qbit_s;
  logic          last_s;
  logic          zero_div_s;

  assign last_s     = (cnt_r == CW'(N - 1));
  assign zero_div_s = (d_r == {N{1'b0}});

  // One restoring step: shifted partial remainder minus divisor, restore on borrow.
  // The trial is N+2 bits wide so its top bit is a reliable sign.
  always_comb begin
    trial_s = {rem_r, qs_r[N-1]} - {2'b00, d_r};
    if (trial_s[N+1]) begin
      rem_step_s = {rem_r[N-1:0], qs_r[N-1]};
      qbit_s     = 1'b0;
    end else begin
      rem_step_s = trial_s[N:0];
      qbit_s     = 1'b1;
    end
  end

  // Next-state logic for the IDLE / CALC / DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        // A zero divisor spends its single CALC cycle publishing the fixed result.
        if (zero_div_s || last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (bus.recieved) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      init_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
      init_r  <= (state_s == IDLE);
    end
  end

  // Operand capture, iterative datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r <= {(N + 1){1'b0}};
      qs_r  <= {N{1'b0}};
      d_r   <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
      q_r   <= {N{1'b0}};
      r_r   <= {N{1'b0}};
      dbz_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load) begin
            rem_r <= {(N + 1){1'b0}};
            qs_r  <= bus.A;
            d_r   <= bus.B;
            cnt_r <= {CW{1'b0}};
          end
        end
        CALC: begin
          if (zero_div_s) begin
            q_r   <= {N{1'b1}};
            r_r   <= qs_r;
            dbz_r <= 1'b1;
          end else begin
            rem_r <= rem_step_s;
            qs_r  <= {qs_r[N-2:0], qbit_s};
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
              q_r   <= {qs_r[N-2:0], qbit_s};
              r_r   <= rem_step_s[N-1:0];
              dbz_r <= 1'b0;
            end
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.done        = done_r;
  assign bus.init        = init_r;
  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_unsigned_divider.sv
// Randomised and directed bench for unsigned_divider against a plain-arithmetic
// model of floor division, remainder and the divide-by-zero convention.
module tb_unsigned_divider;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [N-1:0] exp_q;
  logic [N-1:0] exp_r;
  logic         exp_dbz;

  unsigned_divider_if #(.N(N)) bus ();

  unsigned_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what any correct divider must return for these operands.
  function automatic void set_model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) begin
      exp_q   = '1;
      exp_r   = a;
      exp_dbz = 1'b1;
    end else begin
      exp_q   = a / b;
      exp_r   = a % b;
      exp_dbz = 1'b0;
    end
  endfunction

  // Whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      check("cmp_q", 64'(bus.Q), 64'(exp_q));
      check("cmp_r", 64'(bus.R), 64'(exp_r));
      check("cmp_dbz", 64'(bus.div_by_zero), 64'(exp_dbz));
      check("cmp_init_low", 64'(bus.init), 64'd0);
    end
  end

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    @(posedge clk);
    #2;
    bus.A    = a;
    bus.B    = b;
    bus.load = 1'b1;
    set_model(a, b);
  endtask

  // Counts edges from the accepting edge until done is seen; clears load after it.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) break;
      #1 bus.load = 1'b0;
    end
    if (bus.done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic ack();
    #1 bus.recieved = 1'b1;
    @(posedge clk);
    #1;
    check("ack_init", 64'(bus.init), 64'd1);
    check("ack_done", 64'(bus.done), 64'd0);
    #1 bus.recieved = 1'b0;
    check("hold_q", 64'(bus.Q), 64'(exp_q));
    check("hold_r", 64'(bus.R), 64'(exp_r));
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  vec_t dir[7];
  vec_t b2b[3];

  initial begin
    int lat;
    logic [N-1:0] a;
    logic [N-1:0] b;

    dir[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    dir[1] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0};
    dir[2] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    dir[3] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    dir[4] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    dir[5] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
    dir[6] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    b2b[0] = '{32'd10, 32'd3, 32'd3, 32'd1, 1'b0};
    b2b[1] = '{32'd20, 32'd5, 32'd4, 32'd0, 1'b0};
    b2b[2] = '{32'd12345678, 32'd1234, 32'd10004, 32'd742, 1'b0};

    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.recieved = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    exp_q = '0; exp_r = '0; exp_dbz = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.Q), 64'd0);
    check("rst_r", 64'(bus.R), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    check("rst_init", 64'(bus.init), 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_init", 64'(bus.init), 64'd1);

    // Directed operands with hand-computed results and latency.
    foreach (dir[i]) begin
      launch(dir[i].a, dir[i].b);
      wait_done(lat);
      check("dir_latency", 64'(lat), dir[i].dz ? 64'd2 : 64'(N + 1));
      check("dir_q", 64'(bus.Q), 64'(dir[i].q));
      check("dir_r", 64'(bus.R), 64'(dir[i].r));
      check("dir_dbz", 64'(bus.div_by_zero), 64'(dir[i].dz));
      ack();
    end

    // Operand changes and a stray load during CALC are ignored.
    launch(32'd1000, 32'd3);
    @(posedge clk);
    #2 bus.load = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    bus.A = 32'd7; bus.B = 32'd0; bus.load = 1'b1;
    @(posedge clk);
    #2 bus.load = 1'b0;
    wait_done(lat);
    check("ign_q", 64'(bus.Q), 64'd333);
    check("ign_r", 64'(bus.R), 64'd1);
    ack();

    // Reset in the middle of CALC aborts and clears the results.
    launch(32'd1000, 32'd3);
    @(posedge clk);
    #2 bus.load = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_q", 64'(bus.Q), 64'd0);
    check("midrst_r", 64'(bus.R), 64'd0);
    check("midrst_init", 64'(bus.init), 64'd1);
    #1 rst_n = 1'b1;
    exp_q = '0; exp_r = '0; exp_dbz = 1'b0;

    // Back-to-back with load and recieved both held high in DONE.
    launch(b2b[0].a, b2b[0].b);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      check("b2b_q", 64'(bus.Q), 64'(b2b[i].q));
      check("b2b_r", 64'(bus.R), 64'(b2b[i].r));
      if (i < 2) begin
        #1;
        bus.A = b2b[i+1].a; bus.B = b2b[i+1].b;
        bus.load = 1'b1; bus.recieved = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_idle_init", 64'(bus.init), 64'd1);
        check("b2b_idle_done", 64'(bus.done), 64'd0);
        set_model(b2b[i+1].a, b2b[i+1].b);
        #1 bus.recieved = 1'b0;
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'(N + 1));
      end else begin
        ack();
      end
    end

    // Random sweep, including large operands and occasional zero divisors.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) b = '0;
      launch(a, b);
      wait_done(lat);
      if (b != '0) begin
        check("rnd_identity", 64'(bus.Q) * 64'(b) + 64'(bus.R), 64'(a));
        check("rnd_r_lt_b", 64'(bus.R < b), 64'd1);
      end
      ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
